pmult: RTL and testbench

PMULT -- requirements
Module: pmult

---
 rtl/pmult.sv | 114 +++++++++++
 tb/tb_pmult.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmult.sv
// Pipelined XLEN x XLEN multiplier for MUL/MULH/MULHSU/MULHU. Each of STAGES
// levels folds one slice of the 2*XLEN-extended multiplier into the partial product.
module pmult #(
    parameter int XLEN   = 64,
    parameter int STAGES = 8,
    parameter int TAG_W  = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [XLEN-1:0]  mcand,
    input  logic [XLEN-1:0]  mplier,
    input  logic [1:0]       func,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             stall,
    input  logic             flush,
    output logic [XLEN-1:0]  product,
    output logic             done,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy
);

    localparam int W     = 2 * XLEN;
    localparam int CHUNK = W / STAGES;
    localparam int NREG  = STAGES - 1;

    if ((XLEN % STAGES) != 0 || STAGES < 2) begin : g_badParam
        $error("pmult: XLEN must be a multiple of STAGES and STAGES must be at least 2");
    end

    // Pipeline registers between slices; the last slice writes the output register.
    logic [NREG-1:0]  r_valid;
    logic [1:0]       r_func [NREG];
    logic [TAG_W-1:0] r_tag  [NREG];
    logic [W-1:0]     r_pp   [NREG];
    logic [W-1:0]     r_mc   [NREG];
    logic [W-1:0]     r_mp   [NREG];

    logic             w_mcSigned;
    logic             w_mpSigned;
    logic [W-1:0]     w_mcExt;
    logic [W-1:0]     w_mpExt;

    logic [STAGES-1:0] w_inValid;
    logic [1:0]        w_inFunc [STAGES];
    logic [TAG_W-1:0]  w_inTag  [STAGES];
    logic [W-1:0]      w_inPp   [STAGES];
    logic [W-1:0]      w_inMc   [STAGES];
    logic [W-1:0]      w_inMp   [STAGES];
    logic [W-1:0]      w_outPp  [STAGES];
    logic [W-1:0]      w_finalPp;

    assign w_mcSigned = (func == 2'b01) || (func == 2'b10);
    assign w_mpSigned = (func == 2'b01);
    assign w_mcExt    = {{XLEN{w_mcSigned & mcand[XLEN-1]}}, mcand};
    assign w_mpExt    = {{XLEN{w_mpSigned & mplier[XLEN-1]}}, mplier};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_entry
            assign w_inValid[k] = start;
            assign w_inFunc[k]  = func;
            assign w_inTag[k]   = tag_in;
            assign w_inPp[k]    = '0;
            assign w_inMc[k]    = w_mcExt;
            assign w_inMp[k]    = w_mpExt;
        end else begin : g_pipe
            assign w_inValid[k] = r_valid[k-1];
            assign w_inFunc[k]  = r_func[k-1];
            assign w_inTag[k]   = r_tag[k-1];
            assign w_inPp[k]    = r_pp[k-1];
            assign w_inMc[k]    = r_mc[k-1];
            assign w_inMp[k]    = r_mp[k-1];
        end
        assign w_outPp[k] = w_inPp[k] + (w_inMc[k] * W'(w_inMp[k][CHUNK-1:0]));
    end

    assign w_finalPp = w_outPp[STAGES-1];
    assign busy      = done | (|r_valid);

    // Flush only kills valid bits; product/tag_out keep their last completed values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= '0;
            for (int k = 0; k < NREG; k++) begin
                r_func[k] <= '0;
                r_tag[k]  <= '0;
                r_pp[k]   <= '0;
                r_mc[k]   <= '0;
                r_mp[k]   <= '0;
            end
            product <= '0;
            done    <= 1'b0;
            tag_out <= '0;
        end else if (flush) begin
            r_valid <= '0;
            done    <= 1'b0;
        end else if (!stall) begin
            r_valid <= w_inValid[NREG-1:0];
            for (int k = 0; k < NREG; k++) begin
                r_func[k] <= w_inFunc[k];
                r_tag[k]  <= w_inTag[k];
                r_pp[k]   <= w_outPp[k];
                r_mc[k]   <= w_inMc[k] << CHUNK;
                r_mp[k]   <= w_inMp[k] >> CHUNK;
            end
            done <= w_inValid[STAGES-1];
            if (w_inValid[STAGES-1]) begin
                product <= (w_inFunc[STAGES-1] == 2'b00) ? w_finalPp[XLEN-1:0] : w_finalPp[W-1:XLEN];
                tag_out <= w_inTag[STAGES-1];
            end
        end
    end

endmodule

// File: tb/tb_pmult.sv
// Self-checking bench for pmult: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed results.
module tb_pmult;

    localparam int STAGES = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] mcand;
    logic [63:0] mplier;
    logic [1:0]  func;
    logic [5:0]  tagIn;
    logic        stall;
    logic        flush;
    logic [63:0] product;
    logic        done;
    logic [5:0]  tagOut;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    logic checking = 1'b0;

    pmult #(.XLEN(64), .STAGES(STAGES), .TAG_W(6)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .func    (func),
        .tag_in  (tagIn),
        .stall   (stall),
        .flush   (flush),
        .product (product),
        .done    (done),
        .tag_out (tagOut),
        .busy    (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          remaining;
        logic [63:0] prod;
        logic [5:0]  tag;
    } op_t;

    op_t         inflight[$];
    op_t         head;
    logic        expDone = 1'b0;
    logic [63:0] expProd = '0;
    logic [5:0]  expTag  = '0;

    function automatic logic [63:0] refMul(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa;
        logic signed [127:0] sb;
        logic [127:0]        p;
        sa = (f == 2'b01 || f == 2'b10) ? 128'($signed(a)) : $signed(128'(a));
        sb = (f == 2'b01) ? 128'($signed(b)) : $signed(128'(b));
        p  = sa * sb;
        return (f == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    // Reference model: each accepted op completes after STAGES-1 further unstalled edges.
    always @(posedge clock) begin
        if (reset) begin
            inflight.delete();
            expDone = 1'b0;
            expProd = '0;
            expTag  = '0;
        end else if (flush) begin
            inflight.delete();
            expDone = 1'b0;
        end else if (!stall) begin
            expDone = 1'b0;
            foreach (inflight[i]) inflight[i].remaining--;
            if (inflight.size() > 0 && inflight[0].remaining == 0) begin
                head    = inflight.pop_front();
                expDone = 1'b1;
                expProd = head.prod;
                expTag  = head.tag;
            end
            if (start) inflight.push_back('{remaining: STAGES - 1, prod: refMul(func, mcand, mplier), tag: tagIn});
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (checking) begin
            checkOutput("model done", 64'(done), 64'(expDone));
            checkOutput("model product", product, expProd);
            checkOutput("model tag_out", 64'(tagOut), 64'(expTag));
            checkOutput("model busy", 64'(busy), 64'((inflight.size() != 0) || expDone));
        end
    end

    task automatic applyStimulus(input logic s, input logic [63:0] a, input logic [63:0] b,
                                 input logic [1:0] f, input logic [5:0] t,
                                 input logic stl, input logic fl);
        @(negedge clock);
        start  = s;
        mcand  = a;
        mplier = b;
        func   = f;
        tagIn  = t;
        stall  = stl;
        flush  = fl;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 64'd0, 64'd0, 2'b00, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic waitDone(output int at);
        at = -1000;
        for (int n = 0; n < 40; n++) begin
            if (done === 1'b1) begin
                at = cyc;
                return;
            end
            @(negedge clock);
        end
        checkOutput("done timeout", 64'd0, 64'd1);
    endtask

    task automatic countDone(input int cycles, output int pulses);
        pulses = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clock);
            if (done === 1'b1) pulses++;
        end
    endtask

    logic [1:0]  vecF [8];
    logic [63:0] vecA [8];
    logic [63:0] vecB [8];
    logic [63:0] vecP [8];

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int at;
        int pulses;

        reset = 1'b1; start = 1'b0; mcand = '0; mplier = '0; func = '0;
        tagIn = '0; stall = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset product", product, 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset tag_out", 64'(tagOut), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        reset    = 1'b0;
        checking = 1'b1;

        // Single MUL: latency, value, tag and one-cycle pulse.
        applyStimulus(1'b1, 64'd3, 64'd5, 2'b00, 6'd7, 1'b0, 1'b0);
        base = cyc;
        idle();
        waitDone(at);
        checkOutput("t1 latency", 64'(at - base), 64'd8);
        checkOutput("t1 product", product, 64'd15);
        checkOutput("t1 tag", 64'(tagOut), 64'd7);
        @(negedge clock);
        checkOutput("t1 pulse", 64'(done), 64'd0);

        // Sign/extension corner cases, back to back.
        vecF[0] = 2'b01; vecA[0] = '1;                     vecB[0] = '1;                     vecP[0] = 64'h0;
        vecF[1] = 2'b11; vecA[1] = '1;                     vecB[1] = '1;                     vecP[1] = 64'hFFFF_FFFF_FFFF_FFFE;
        vecF[2] = 2'b10; vecA[2] = '1;                     vecB[2] = 64'd2;                  vecP[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        vecF[3] = 2'b00; vecA[3] = 64'h8000_0000_0000_0000; vecB[3] = 64'd2;                  vecP[3] = 64'h0;
        vecF[4] = 2'b01; vecA[4] = 64'h8000_0000_0000_0000; vecB[4] = 64'h8000_0000_0000_0000; vecP[4] = 64'h4000_0000_0000_0000;
        vecF[5] = 2'b10; vecA[5] = 64'h8000_0000_0000_0000; vecB[5] = '1;                     vecP[5] = 64'h8000_0000_0000_0000;
        vecF[6] = 2'b00; vecA[6] = 64'd0;                  vecB[6] = '1;                     vecP[6] = 64'h0;
        vecF[7] = 2'b00; vecA[7] = '1;                     vecB[7] = '1;                     vecP[7] = 64'h1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, vecA[i], vecB[i], vecF[i], 6'(10 + i), 1'b0, 1'b0);
            if (i == 0) base = cyc;
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            waitDone(at);
            if (i == 0) checkOutput("t2 latency", 64'(at - base), 64'd8);
            checkOutput($sformatf("t2 product %0d", i), product, vecP[i]);
            checkOutput($sformatf("t2 tag %0d", i), 64'(tagOut), 64'(10 + i));
            @(negedge clock);
        end

        // Eight back-to-back ops i x (i+1), results in issue order.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 64'(i), 64'(i + 1), 2'b00, 6'(i), 1'b0, 1'b0);
            if (i == 0) base = cyc;
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            waitDone(at);
            checkOutput($sformatf("t3 cycle %0d", i), 64'(at - base), 64'(8 + i));
            checkOutput($sformatf("t3 product %0d", i), product, 64'(i * (i + 1)));
            checkOutput($sformatf("t3 tag %0d", i), 64'(tagOut), 64'(i));
            @(negedge clock);
        end

        // Stall for cycles 3..5 delays completion by three; a start while stalled is ignored.
        applyStimulus(1'b1, 64'd1000, 64'd77, 2'b00, 6'd33, 1'b0, 1'b0);
        base = cyc;
        idle();
        idle();
        applyStimulus(1'b0, 64'd0, 64'd0, 2'b00, 6'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 64'd9, 64'd9, 2'b00, 6'd60, 1'b1, 1'b0);
        applyStimulus(1'b0, 64'd0, 64'd0, 2'b00, 6'd0, 1'b1, 1'b0);
        idle();
        waitDone(at);
        checkOutput("t4 latency", 64'(at - base), 64'd11);
        checkOutput("t4 product", product, 64'd77000);
        checkOutput("t4 tag", 64'(tagOut), 64'd33);
        countDone(12, pulses);
        checkOutput("t4 stalled start ignored", 64'(pulses), 64'd0);

        // Flush with a simultaneous start kills everything in flight.
        applyStimulus(1'b1, 64'd7, 64'd7, 2'b00, 6'd20, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'd8, 64'd8, 2'b00, 6'd21, 1'b0, 1'b0);
        base = cyc;
        applyStimulus(1'b1, 64'd9, 64'd9, 2'b00, 6'd22, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'd4, 64'd4, 2'b00, 6'd23, 1'b0, 1'b1);
        idle();
        checkOutput("t5 busy after flush", 64'(busy), 64'd0);
        checkOutput("t5 cycle", 64'(cyc - base), 64'd3);
        countDone(15, pulses);
        checkOutput("t5 no done", 64'(pulses), 64'd0);

        // Reset mid-operation discards work and clears outputs.
        applyStimulus(1'b1, 64'd5, 64'd6, 2'b11, 6'd40, 1'b0, 1'b0);
        base = cyc;
        applyStimulus(1'b1, 64'd5, 64'd6, 2'b00, 6'd41, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'd5, 64'd7, 2'b00, 6'd42, 1'b0, 1'b0);
        idle();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("t6 product", product, 64'd0);
        checkOutput("t6 done", 64'(done), 64'd0);
        checkOutput("t6 tag", 64'(tagOut), 64'd0);
        checkOutput("t6 busy", 64'(busy), 64'd0);
        applyStimulus(1'b1, 64'd12, 64'd12, 2'b00, 6'd50, 1'b0, 1'b0);
        idle();
        waitDone(at);
        checkOutput("t6 latency", 64'(at - base), 64'd14);
        checkOutput("t6 new product", product, 64'd144);
        checkOutput("t6 new tag", 64'(tagOut), 64'd50);

        // Mixed directed vectors with stalls sprinkled in, checked by the model.
        vecF[0] = 2'b01; vecA[0] = 64'h7FFF_FFFF_FFFF_FFFF; vecB[0] = 64'hFFFF_FFFF_FFFF_FFFD;
        vecF[1] = 2'b10; vecA[1] = 64'hFFFF_FFFF_FFFF_FFFB; vecB[1] = 64'hF000_0000_0000_0000;
        vecF[2] = 2'b11; vecA[2] = 64'h1234_5678_9ABC_DEF0; vecB[2] = 64'h0FED_CBA9_8765_4321;
        vecF[3] = 2'b00; vecA[3] = 64'hDEAD_BEEF_CAFE_BABE; vecB[3] = 64'h0123_4567_89AB_CDEF;
        vecF[4] = 2'b01; vecA[4] = 64'h8000_0000_0000_0000; vecB[4] = 64'h7FFF_FFFF_FFFF_FFFF;
        vecF[5] = 2'b10; vecA[5] = 64'd3;                  vecB[5] = 64'hFFFF_FFFF_FFFF_FFFF;
        vecF[6] = 2'b11; vecA[6] = 64'h8000_0000_0000_0000; vecB[6] = 64'h8000_0000_0000_0000;
        vecF[7] = 2'b00; vecA[7] = 64'h0000_0001_0000_0000; vecB[7] = 64'h0000_0001_0000_0000;
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, vecA[i], vecB[i], vecF[i], 6'(i + 1), (i == 2) || (i == 5), 1'b0);
        idle();
        repeat (12) @(negedge clock);

        // Flush outranks stall.
        applyStimulus(1'b1, 64'd11, 64'd13, 2'b00, 6'd61, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'd17, 64'd19, 2'b00, 6'd62, 1'b0, 1'b0);
        applyStimulus(1'b0, 64'd0, 64'd0, 2'b00, 6'd0, 1'b1, 1'b1);
        idle();
        countDone(14, pulses);
        checkOutput("t8 flush over stall", 64'(pulses), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
